// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers digit codes from a scanned, active-low 7-segment display bus.
// Ports: clk, rst_n (async, active-low); seg_in = {a..g, dp} active-low; an_in active-low digit select;
// digits = 4-bit code per position; dp = lit decimal points; frame_done = one-cycle update strobe;
// err_pos = per-position flag for an unrecognized segment pattern.
module seg_scan_decoder #(
  parameter int NDIG = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           seg_in,
  input  logic [NDIG-1:0]      an_in,
  output logic [4*NDIG-1:0]    digits,
  output logic [NDIG-1:0]      dp,
  output logic                 frame_done,
  output logic [NDIG-1:0]      err_pos
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  typedef enum logic {SETTLE, HOLD} state_t;
  state_t               state;
  logic [7:0]           s_seg, p_seg;
  logic [NDIG-1:0]      s_an, p_an, sel, seen, sh_dp, sh_err;
  logic [4*NDIG-1:0]    sh_code;
  logic [CW-1:0]        cnt;
  logic [3:0]           code;
  logic                 same, valid, cap, bad;
  assign sel   = ~s_an;
  assign valid = (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);
  assign same  = (s_seg == p_seg) && (s_an == p_an);
  // cnt becomes STABLE_CYC-1 on the capture edge, which is the STABLE_CYC-th identical sample
  assign cap   = (state == SETTLE) && same && valid && (cnt == CW'(STABLE_CYC - 2));
  assign bad   = (code == 4'hE);
  always_comb begin
    code = 4'hE;
    case (s_seg[7:1])
      7'b0000001: code = 4'd0;
      7'b1001111: code = 4'd1;
      7'b0010010: code = 4'd2;
      7'b0000110: code = 4'd3;
      7'b1001100: code = 4'd4;
      7'b0100100: code = 4'd5;
      7'b0100000: code = 4'd6;
      7'b0001111: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0000100: code = 4'd9;
      7'b1111111: code = 4'hF;
      default:    code = 4'hE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg      <= '1;
      s_an       <= '1;
      p_seg      <= '1;
      p_an       <= '1;
      cnt        <= '0;
      state      <= SETTLE;
      seen       <= '0;
      sh_code    <= '1;
      sh_dp      <= '0;
      sh_err     <= '0;
      digits     <= '1;
      dp         <= '0;
      err_pos    <= '0;
      frame_done <= 1'b0;
    end else begin
      s_seg      <= seg_in;
      s_an       <= an_in;
      p_seg      <= s_seg;
      p_an       <= s_an;
      cnt        <= !(same && valid) ? '0 : (cnt == CW'(STABLE_CYC)) ? cnt : cnt + CW'(1);
      state      <= cap ? HOLD : !same ? SETTLE : state;
      frame_done <= &seen;
      // a capture landing on the completion edge survives the clear and starts the next frame
      seen       <= (&seen ? '0 : seen) | (cap ? sel : '0);
      if (&seen) begin
        digits  <= sh_code;
        dp      <= sh_dp;
        err_pos <= sh_err;
      end
      for (int i = 0; i < NDIG; i++)
        if (cap && sel[i]) begin
          sh_code[4*i+:4] <= code;
          sh_dp[i]        <= ~s_seg[0];
          sh_err[i]       <= bad;
        end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: scoreboard bench for the scanned 7-segment decoder.
module tb_seg_scan_decoder;
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  e;
  } frame_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_in = '1;
  logic [3:0]  an_in = '1;
  logic [15:0] digits;
  logic [3:0]  dp, err_pos;
  logic        frame_done;
  int          checks = 0, errors = 0, frames = 0, cyc = 0, drive_cyc = 0, done_cyc = 0;
  logic        prev_fd = 1'b0;
  frame_t      exp_q[$];
  frame_t      got;
  logic [6:0]  pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  seg_scan_decoder #(.NDIG(4), .STABLE_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .digits(digits), .dp(dp), .frame_done(frame_done), .err_pos(err_pos)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  always @(negedge clk) begin
    if (prev_fd) chk("fd_one_cycle", 32'(frame_done), 0);
    if (frame_done) begin
      frames++;
      done_cyc = cyc;
      chk("frame_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("frame_digits", 32'(digits), 32'(got.d));
        chk("frame_dp", 32'(dp), 32'(got.p));
        chk("frame_err", 32'(err_pos), 32'(got.e));
      end
    end
    prev_fd = frame_done;
  end
  function automatic logic [7:0] sg(input logic [3:0] c, input logic d);
    return {pat[c], ~d};
  endfunction
  task automatic show(input int pos, input logic [7:0] seg, input int n);
    an_in = ~(4'b1 << pos);
    seg_in = seg;
    drive_cyc = cyc;
    repeat (n) @(negedge clk);
  endtask
  task automatic idle(input int n);
    an_in = '1;
    seg_in = '1;
    repeat (n) @(negedge clk);
  endtask
  task automatic scan(input logic [15:0] codes, input logic [3:0] dps, input int dwell);
    exp_q.push_back({codes, dps, 4'b0});
    for (int i = 0; i < 4; i++) show(i, sg(codes[4*i+:4], dps[i]), dwell);
  endtask
  initial begin
    logic [15:0] rc;
    logic [3:0]  rd;
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(digits), 32'hFFFF);
    chk("rst_dp", 32'(dp), 0);
    chk("rst_err", 32'(err_pos), 0);
    chk("rst_fd", 32'(frame_done), 0);
    rst_n = 1'b1;
    idle(3);
    scan(16'h4321, 4'b0, 8);
    chk("latency", 32'(done_cyc - drive_cyc), 6);
    idle(5);
    chk("frames_basic", 32'(frames), 1);
    show(1, sg(6, 0), 8);
    show(2, sg(7, 0), 8);
    show(3, sg(8, 0), 8);
    show(0, sg(9, 0), 3);
    show(0, sg(0, 0), 1);
    show(0, sg(9, 0), 3);
    idle(10);
    chk("glitch_no_capture", 32'(frames), 1);
    exp_q.push_back({16'h8769, 4'b0, 4'b0});
    show(0, sg(9, 0), 20);
    idle(5);
    chk("long_dwell_frame", 32'(frames), 2);
    show(1, sg(1, 0), 8);
    show(2, sg(2, 0), 8);
    show(3, sg(3, 0), 8);
    idle(10);
    chk("once_per_dwell", 32'(frames), 2);
    exp_q.push_back({16'h3215, 4'b0, 4'b0});
    show(0, sg(5, 0), 8);
    idle(5);
    chk("frames_after_dwell", 32'(frames), 3);
    show(0, sg(0, 0), 8);
    show(1, sg(1, 0), 8);
    show(2, sg(2, 0), 8);
    an_in = 4'b0011;
    seg_in = sg(8, 0);
    repeat (10) @(negedge clk);
    idle(5);
    chk("multi_low_no_capture", 32'(frames), 3);
    exp_q.push_back({16'h9210, 4'b0, 4'b0});
    show(3, sg(9, 0), 8);
    idle(5);
    chk("frames_after_invalid", 32'(frames), 4);
    exp_q.push_back({16'h8FE0, 4'b0100, 4'b0010});
    show(0, sg(0, 0), 8);
    show(1, 8'b0110_1101, 8);
    show(2, 8'b1111_1110, 8);
    show(3, sg(8, 0), 8);
    idle(5);
    chk("frames_blank_err", 32'(frames), 5);
    show(0, sg(7, 0), 8);
    show(1, sg(7, 0), 8);
    show(2, sg(7, 0), 8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(digits), 32'hFFFF);
    chk("async_rst_dp", 32'(dp), 0);
    chk("async_rst_err", 32'(err_pos), 0);
    chk("async_rst_fd", 32'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    show(3, sg(1, 0), 8);
    idle(10);
    chk("no_frame_after_rst", 32'(frames), 5);
    exp_q.push_back({16'h1654, 4'b0, 4'b0});
    show(0, sg(4, 0), 8);
    show(1, sg(5, 0), 8);
    show(2, sg(6, 0), 8);
    idle(5);
    chk("frame_after_rescan", 32'(frames), 6);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) rc[4*i+:4] = 4'($urandom_range(0, 9));
      rd = 4'($urandom_range(0, 15));
      scan(rc, rd, 5 + 2 * f);
    end
    idle(10);
    chk("frames_continuous", 32'(frames), 9);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
